// File: rtl/neopix_pkg.sv
// -----------------------------------------------------------------------------
// neopix_pkg
// Shared definitions for the WS2812B frame sequencer:
//   - state_t   : sequencer FSM states
//   - PIX_W     : width of one GRB pixel word
//   - *_DEF     : default bit / latch timing in clock cycles
// -----------------------------------------------------------------------------
package neopix_pkg;

    localparam int PIX_W = 24;

    localparam int T0H_DEF   = 4;
    localparam int T1H_DEF   = 12;
    localparam int T_BIT_DEF = 16;
    localparam int RET_DEF   = 800;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        SEND  = 3'd3,
        LATCH = 3'd4,
        DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/neopix_bit_encoder.sv
// -----------------------------------------------------------------------------
// neopix_bit_encoder
// Serialises one 24-bit GRB word MSB-first onto the WS2812B line. Each bit lasts
// T_BIT cycles: high for T0H (0 bit) or T1H (1 bit) cycles, then low.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   load       : take data into the shift register; bit 23 starts next cycle.
//                Has priority over shifting, so a load on the last cycle of
//                bit 0 gives a zero-gap pixel boundary.
//   data       : word to serialise
//   out        : WS2812B data line
//   word_done  : pulse on the last cycle of bit 0
//   first_bit  : pulse on the first cycle of bit 23
// -----------------------------------------------------------------------------
module neopix_bit_encoder
    import neopix_pkg::*;
#(
    parameter int T0H   = T0H_DEF,
    parameter int T1H   = T1H_DEF,
    parameter int T_BIT = T_BIT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [PIX_W-1:0] data,
    output logic             out,
    output logic             word_done,
    output logic             first_bit
);

    localparam int CNT_W = $clog2(T_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(T_BIT - 1);
    localparam logic [CNT_W-1:0] HI0      = CNT_W'(T0H);
    localparam logic [CNT_W-1:0] HI1      = CNT_W'(T1H);

    logic [PIX_W-1:0] shreg;
    logic [CNT_W-1:0] cyc_cnt;
    logic [4:0]       bit_idx;
    logic             active;

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= '0;
            cyc_cnt <= '0;
            bit_idx <= '0;
            active  <= 1'b0;
        end else if (load) begin
            shreg   <= data;
            cyc_cnt <= '0;
            bit_idx <= 5'd23;
            active  <= 1'b1;
        end else if (active) begin
            if (cyc_cnt == CNT_LAST) begin
                cyc_cnt <= '0;
                shreg   <= {shreg[PIX_W-2:0], 1'b0};
                if (bit_idx == 5'd0) begin
                    active <= 1'b0;
                end else begin
                    bit_idx <= bit_idx - 5'd1;
                end
            end else begin
                cyc_cnt <= cyc_cnt + CNT_W'(1);
            end
        end
    end

    // The current bit always sits in the MSB of the shift register.
    assign out       = active && (cyc_cnt < (shreg[PIX_W-1] ? HI1 : HI0));
    assign word_done = active && (bit_idx == 5'd0)  && (cyc_cnt == CNT_LAST);
    assign first_bit = active && (bit_idx == 5'd23) && (cyc_cnt == '0);

endmodule

// File: rtl/neopix_frame_sequencer.sv
// -----------------------------------------------------------------------------
// neopix_frame_sequencer
// Walks a pixel buffer of NUM_PIXELS GRB words, streams them back-to-back
// through neopix_bit_encoder, then holds the line low for RET cycles so the
// LED chain latches. Optionally free-runs frames while auto_refresh is high.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (aborts a frame)
//   start         : request one frame, sampled only in IDLE
//   auto_refresh  : high on the final latch cycle -> next frame immediately
//   mem_rd_en     : pixel-buffer read strobe
//   mem_addr      : pixel index being read
//   mem_rd_data   : GRB word, valid the cycle after mem_rd_en
//   busy          : frame in progress (any state but IDLE)
//   done          : one-cycle pulse after the latch gap
//   out           : WS2812B data line
//
// Memory read port: mem_rd_en is a single-cycle request qualified with
// mem_addr; the word appears on mem_rd_data exactly one cycle later and there
// is no back-pressure. mem_rd_data is sampled only in LOAD and in the cycle
// after a prefetch strobe.
// -----------------------------------------------------------------------------
module neopix_frame_sequencer
    import neopix_pkg::*;
#(
    parameter int NUM_PIXELS = 8,
    parameter int ADDR_W     = 8,
    parameter int T0H        = T0H_DEF,
    parameter int T1H        = T1H_DEF,
    parameter int T_BIT      = T_BIT_DEF,
    parameter int RET        = RET_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              auto_refresh,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_rd_data,
    output logic              busy,
    output logic              done,
    output logic              out
);

    localparam int LAT_W = $clog2(RET + 1);
    localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(RET - 1);
    localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(NUM_PIXELS - 1);

    state_t             state;
    state_t             state_nx;
    logic [ADDR_W-1:0]  pix_idx;
    logic [LAT_W-1:0]   lat_cnt;
    logic [PIX_W-1:0]   hold;
    logic               pf_capture;
    logic               enc_load;
    logic [PIX_W-1:0]   enc_data;
    logic               word_done;
    logic               first_bit;
    logic               last_pix;

    assign last_pix = (pix_idx == PIX_LAST);

    neopix_bit_encoder #(
        .T0H   (T0H),
        .T1H   (T1H),
        .T_BIT (T_BIT)
    ) u_enc (
        .clk       (clk),
        .rst       (rst),
        .load      (enc_load),
        .data      (enc_data),
        .out       (out),
        .word_done (word_done),
        .first_bit (first_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        mem_rd_en = 1'b0;
        mem_addr  = pix_idx;
        enc_load  = 1'b0;
        enc_data  = hold;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nx = FETCH;
                end
            end
            FETCH: begin
                mem_rd_en = 1'b1;
                state_nx  = LOAD;
            end
            LOAD: begin
                enc_load = 1'b1;
                enc_data = mem_rd_data;
                state_nx = SEND;
            end
            SEND: begin
                // Prefetch the next pixel while the current one is still
                // 24 bit periods from finishing.
                if (first_bit && !last_pix) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = pix_idx + ADDR_W'(1);
                end
                if (word_done) begin
                    if (last_pix) begin
                        state_nx = LATCH;
                    end else begin
                        enc_load = 1'b1;
                    end
                end
            end
            LATCH: begin
                if (lat_cnt == LAT_LAST) begin
                    state_nx = auto_refresh ? FETCH : DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_idx    <= '0;
            lat_cnt    <= '0;
            hold       <= '0;
            pf_capture <= 1'b0;
        end else begin
            pf_capture <= (state == SEND) && mem_rd_en;
            if (pf_capture) begin
                hold <= mem_rd_data;
            end

            if (state == LATCH) begin
                lat_cnt <= lat_cnt + LAT_W'(1);
            end else begin
                lat_cnt <= '0;
            end

            case (state)
                IDLE: pix_idx <= '0;
                SEND: begin
                    if (word_done && !last_pix) begin
                        pix_idx <= pix_idx + ADDR_W'(1);
                    end
                end
                LATCH: begin
                    // Auto-refresh re-enters FETCH, which reads pixel 0.
                    if (lat_cnt == LAT_LAST) begin
                        pix_idx <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
